vgalcd_pixel_unpack: RTL and testbench

Parametrised pixel fetch-and-unpack stage for the VGA/LCD controller. It sits between the framebuffer read port and the RGB output mux. A FIFO of bus words decouples the read handshake from display-enable, so words can be prefetched during blanking. It unpacks 8 bpp (RGB332) or 16 bpp (RGB444/555/565) pixels from BUS_WIDTH-bit words, one pixel per pixel-clock enable, and reports underflow.

---
 rtl/vgalcd_pixel_unpack.sv | 147 ++++++++++++++
 tb/tb_vgalcd_pixel_unpack.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vgalcd_pixel_unpack.sv
// Pixel fetch-and-unpack stage: buffers framebuffer words in a small FIFO and
// emits one RGB332/444/555/565 pixel per pixel-clock enable, flagging underflow.
module vgalcd_pixel_unpack #(
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [1:0]           mode_i,
  input  logic                 frame_start_i,
  input  logic                 pclk_en_i,
  input  logic                 de_i,
  input  logic                 pixel_valid_i,
  output logic                 pixel_ready_o,
  input  logic [BUS_WIDTH-1:0] pixel_data_i,
  output logic [15:0]          pix_o,
  output logic                 underflow_o,
  input  logic                 underflow_clr_i,
  output logic [LVL_WIDTH-1:0] level_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PPW8  = BUS_WIDTH / 8;
  localparam int unsigned PPW16 = BUS_WIDTH / 16;
  localparam int unsigned IDX_W = $clog2(PPW8);
  localparam int unsigned SH_W  = $clog2(BUS_WIDTH);

  logic [BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [LVL_WIDTH-1:0] count_q, count_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           mode_q, mode_d;
  logic [15:0]          pix_q, pix_d;
  logic                 underflow_q, underflow_d;

  logic                 full, empty, flush, push, pop, step;
  logic [IDX_W-1:0]     last_idx;
  logic [BUS_WIDTH-1:0] head;
  logic [SH_W-1:0]      sh8, sh16;
  logic [15:0]          pix_sel;

  // Handshake and pixel-step qualifiers
  always_comb begin
    full          = (count_q == LVL_WIDTH'(FIFO_DEPTH));
    empty         = (count_q == '0);
    flush         = frame_start_i | ~en_i;
    pixel_ready_o = en_i & ~full & ~frame_start_i;
    push          = pixel_valid_i & pixel_ready_o;
    step          = pclk_en_i & de_i & en_i;
    last_idx      = (mode_q == 2'b00) ? IDX_W'(PPW8 - 1) : IDX_W'(PPW16 - 1);
    pop           = step & ~empty & (idx_q == last_idx) & ~flush;
  end

  // Lane select from the head word; pixel 0 sits in the LSBs
  always_comb begin
    head    = mem_q[rptr_q];
    sh8     = SH_W'(idx_q) << 3;
    sh16    = SH_W'(idx_q) << 4;
    pix_sel = head[sh16 +: 16];
    if (mode_q == 2'b00) begin
      pix_sel = {8'h00, head[sh8 +: 8]};
    end
  end

  // Next-state logic; flush overrides push, pop and pixel step
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    pix_d       = pix_q;
    underflow_d = underflow_q;

    if (frame_start_i) begin
      mode_d = mode_i;
    end

    if (underflow_clr_i) begin
      underflow_d = 1'b0;
    end

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      idx_d   = '0;
      pix_d   = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      count_d = count_q + LVL_WIDTH'(push) - LVL_WIDTH'(pop);

      if (pclk_en_i) begin
        if (!de_i) begin
          pix_d = '0;
        end else if (empty) begin
          pix_d       = '0;
          underflow_d = 1'b1;
        end else begin
          pix_d = pix_sel;
          idx_d = (idx_q == last_idx) ? '0 : idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Word storage needs no reset; count gates every read
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem_q[wptr_q] <= pixel_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      mode_q      <= 2'b00;
      pix_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
    end
  end

  assign pix_o       = pix_q;
  assign underflow_o = underflow_q;
  assign level_o     = count_q;

endmodule

// File: tb/tb_vgalcd_pixel_unpack.sv
// Directed bench for vgalcd_pixel_unpack: fill, 16/8 bpp unpack, flush priority,
// underflow stickiness, and sustained push/pop across pointer wrap.
module tb_vgalcd_pixel_unpack;

  localparam int unsigned BW = 64;
  localparam int unsigned LW = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          en_i;
  logic [1:0]    mode_i;
  logic          frame_start_i;
  logic          pclk_en_i;
  logic          de_i;
  logic          pixel_valid_i;
  logic          pixel_ready_o;
  logic [BW-1:0] pixel_data_i;
  logic [15:0]   pix_o;
  logic          underflow_o;
  logic          underflow_clr_i;
  logic [LW-1:0] level_o;

  int n_cmp  = 0;
  int n_fail = 0;

  vgalcd_pixel_unpack #(.BUS_WIDTH(BW), .FIFO_DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .en_i           (en_i),
    .mode_i         (mode_i),
    .frame_start_i  (frame_start_i),
    .pclk_en_i      (pclk_en_i),
    .de_i           (de_i),
    .pixel_valid_i  (pixel_valid_i),
    .pixel_ready_o  (pixel_ready_o),
    .pixel_data_i   (pixel_data_i),
    .pix_o          (pix_o),
    .underflow_o    (underflow_o),
    .underflow_clr_i(underflow_clr_i),
    .level_o        (level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied at negedge take effect at the posedge, then sample at negedge
  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  logic [BW-1:0] fill_w [6];
  int            n_acc;
  logic [15:0]   exp16;

  initial begin
    fill_w[0] = 64'h4444_3333_2222_1111;
    fill_w[1] = 64'h8888_7777_6666_5555;
    fill_w[2] = 64'hCCCC_BBBB_AAAA_9999;
    fill_w[3] = 64'h0123_4567_89AB_CDEF;
    fill_w[4] = 64'hDEAD_BEEF_DEAD_BEEF;
    fill_w[5] = 64'hFEED_FACE_FEED_FACE;

    rst_n_i = 1'b0; en_i = 1'b0; mode_i = 2'b00; frame_start_i = 1'b0;
    pclk_en_i = 1'b0; de_i = 1'b0; pixel_valid_i = 1'b0; pixel_data_i = '0;
    underflow_clr_i = 1'b0;
    cyc(); cyc();
    chk("rst_pix", 64'(pix_o), 64'h0);
    chk("rst_uf", 64'(underflow_o), 64'h0);
    chk("rst_level", 64'(level_o), 64'h0);
    chk("rst_ready", 64'(pixel_ready_o), 64'h0);
    rst_n_i = 1'b1;
    cyc();

    // Latch RGB565 with a frame start; ready is masked that cycle
    en_i = 1'b1; mode_i = 2'b11; frame_start_i = 1'b1;
    #1;
    chk("fs_ready_mask", 64'(pixel_ready_o), 64'h0);
    cyc();
    frame_start_i = 1'b0;
    chk("fs_level", 64'(level_o), 64'h0);

    // Fill during blanking: pclk runs with de low, pix must stay 0
    n_acc = 0;
    pclk_en_i = 1'b1; de_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pixel_valid_i = 1'b1;
      pixel_data_i  = fill_w[i];
      #1;
      if (pixel_ready_o) n_acc++;
      cyc();
    end
    pixel_valid_i = 1'b0; pclk_en_i = 1'b0;
    #1;
    chk("fill_accepted", 64'(n_acc), 64'd4);
    chk("fill_level", 64'(level_o), 64'd4);
    chk("fill_ready", 64'(pixel_ready_o), 64'h0);
    chk("fill_pix", 64'(pix_o), 64'h0);

    // 16 bpp unpack with pclk every 2 clocks
    de_i = 1'b1;
    pclk_en_i = 1'b1; cyc(); chk("p16_0", 64'(pix_o), 64'h1111); chk("p16_lvl0", 64'(level_o), 64'd4);
    pclk_en_i = 1'b0; cyc(); chk("p16_hold", 64'(pix_o), 64'h1111);
    pclk_en_i = 1'b1; cyc(); chk("p16_1", 64'(pix_o), 64'h2222);
    pclk_en_i = 1'b0; cyc();
    pclk_en_i = 1'b1; cyc(); chk("p16_2", 64'(pix_o), 64'h3333); chk("p16_lvl2", 64'(level_o), 64'd4);
    pclk_en_i = 1'b0; cyc();
    pclk_en_i = 1'b1; cyc(); chk("p16_3", 64'(pix_o), 64'h4444); chk("p16_pop", 64'(level_o), 64'd3);
    pclk_en_i = 1'b0; cyc();
    pclk_en_i = 1'b1; cyc(); chk("p16_4", 64'(pix_o), 64'h5555);
    pclk_en_i = 1'b0; cyc();
    pclk_en_i = 1'b1; cyc(); chk("p16_5", 64'(pix_o), 64'h6666); chk("p16_lvl5", 64'(level_o), 64'd3);
    pclk_en_i = 1'b0; de_i = 1'b0;
    cyc();

    // Flush with a coincident valid word: word dropped, new mode latched
    frame_start_i = 1'b1; mode_i = 2'b00; pixel_valid_i = 1'b1; pixel_data_i = fill_w[4];
    #1;
    chk("flush_ready", 64'(pixel_ready_o), 64'h0);
    cyc();
    frame_start_i = 1'b0;
    chk("flush_level", 64'(level_o), 64'h0);
    chk("flush_pix", 64'(pix_o), 64'h0);
    chk("flush_uf", 64'(underflow_o), 64'h0);

    // 8 bpp unpack from idx 0; mid-frame mode change ignored
    pixel_data_i = 64'h0807_0605_0403_0201;
    cyc();
    pixel_valid_i = 1'b0;
    chk("p8_level", 64'(level_o), 64'd1);
    mode_i = 2'b11; de_i = 1'b1; pclk_en_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("p8_%0d", k), 64'(pix_o), 64'(k + 1));
    end
    chk("p8_pop", 64'(level_o), 64'h0);
    chk("p8_uf0", 64'(underflow_o), 64'h0);

    // Underflow on empty FIFO, sticky through frame start
    cyc();
    chk("uf_pix", 64'(pix_o), 64'h0);
    chk("uf_set", 64'(underflow_o), 64'h1);
    pclk_en_i = 1'b0; de_i = 1'b0; frame_start_i = 1'b1;
    cyc();
    frame_start_i = 1'b0;
    chk("uf_sticky", 64'(underflow_o), 64'h1);
    underflow_clr_i = 1'b1;
    cyc();
    underflow_clr_i = 1'b0;
    chk("uf_clr", 64'(underflow_o), 64'h0);
    // Clear coinciding with a new underflow: set wins
    underflow_clr_i = 1'b1; de_i = 1'b1; pclk_en_i = 1'b1;
    cyc();
    underflow_clr_i = 1'b0; de_i = 1'b0; pclk_en_i = 1'b0;
    chk("uf_setwins", 64'(underflow_o), 64'h1);
    underflow_clr_i = 1'b1;
    cyc();
    underflow_clr_i = 1'b0;
    chk("uf_clr2", 64'(underflow_o), 64'h0);

    // Wrap: word k carries pixels 4k..4k+3 so the stream counts up
    for (int k = 0; k < 2; k++) begin
      pixel_valid_i = 1'b1;
      pixel_data_i  = {16'(4 * k + 3), 16'(4 * k + 2), 16'(4 * k + 1), 16'(4 * k)};
      cyc();
    end
    pixel_valid_i = 1'b0;
    chk("wrap_prefill", 64'(level_o), 64'd2);
    de_i = 1'b1; pclk_en_i = 1'b1;
    for (int s = 0; s < 80; s++) begin
      pixel_valid_i = ((s % 4) == 3);
      pixel_data_i  = {16'(4 * (s / 4 + 2) + 3), 16'(4 * (s / 4 + 2) + 2),
                       16'(4 * (s / 4 + 2) + 1), 16'(4 * (s / 4 + 2))};
      cyc();
      exp16 = 16'(s);
      chk($sformatf("wrap_pix_%0d", s), 64'(pix_o), 64'(exp16));
      chk($sformatf("wrap_lvl_%0d", s), 64'(level_o), 64'd2);
    end
    pixel_valid_i = 1'b0; de_i = 1'b0; pclk_en_i = 1'b0;

    // Asynchronous reset mid-operation
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_level", 64'(level_o), 64'h0);
    chk("arst_pix", 64'(pix_o), 64'h0);
    cyc();
    rst_n_i = 1'b1;
    cyc();

    // en low acts as flush and masks ready
    en_i = 1'b0;
    #1;
    chk("en_low_ready", 64'(pixel_ready_o), 64'h0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
